// File: rtl/ov7670_stream_pkg.sv
// Shared definitions for the OV7670 camera stream generator: FSM states,
// pattern codes, byte constants and default frame timing.
package ov7670_stream_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBP,
        ST_ACTIVE,
        ST_VFP
    } state_t;

    localparam logic [1:0] PAT_GRAY    = 2'd0;
    localparam logic [1:0] PAT_RAMP    = 2'd1;
    localparam logic [1:0] PAT_CHECKER = 2'd2;
    localparam logic [1:0] PAT_MOVING  = 2'd3;

    localparam logic [7:0] CHROMA_BYTE = 8'h80;
    localparam logic [7:0] GRAY_Y      = 8'h80;

    localparam int DEF_H_PIXELS     = 640;
    localparam int DEF_V_LINES      = 480;
    localparam int DEF_H_BLANK_CLKS = 288;
    localparam int DEF_VSYNC_LINES  = 3;
    localparam int DEF_VBP_LINES    = 17;
    localparam int DEF_VFP_LINES    = 10;

    // Width of the column and line counters and of the pixel coordinates.
    localparam int CNT_W = 16;

endpackage

// File: rtl/ov7670_pattern_gen.sv
// Combinational byte generator: maps pattern, pixel coordinates and byte
// phase (0 = Y, 1 = chroma) to the byte placed on the camera bus.
module ov7670_pattern_gen
    import ov7670_stream_pkg::*;
(
    input  logic [1:0]       pattern,
    input  logic [CNT_W-1:0] x,
    input  logic [CNT_W-1:0] y,
    input  logic             phase,
    input  logic [7:0]       frame_count,
    output logic [7:0]       data
);

    logic [7:0] y_byte;
    logic       unused_bits;

    assign unused_bits = ^{x[CNT_W-1:8], y[CNT_W-1:4], y[2:0]};

    always_comb begin
        case (pattern)
            PAT_GRAY:    y_byte = GRAY_Y;
            PAT_RAMP:    y_byte = x[7:0];
            PAT_CHECKER: y_byte = (x[3] ^ y[3]) ? 8'hFF : 8'h00;
            default:     y_byte = x[7:0] + frame_count;
        endcase
        data = phase ? CHROMA_BYTE : y_byte;
    end

endmodule

// File: rtl/ov7670_stream_gen.sv
// OV7670-style video source: frame FSM with line/column counters producing
// vsync, href and YUV bytes, all registered on enabled clocks.
module ov7670_stream_gen
    import ov7670_stream_pkg::*;
#(
    parameter int H_PIXELS     = DEF_H_PIXELS,
    parameter int V_LINES      = DEF_V_LINES,
    parameter int H_BLANK_CLKS = DEF_H_BLANK_CLKS,
    parameter int VSYNC_LINES  = DEF_VSYNC_LINES,
    parameter int VBP_LINES    = DEF_VBP_LINES,
    parameter int VFP_LINES    = DEF_VFP_LINES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       start,
    input  logic       continuous,
    input  logic [1:0] pattern_sel,
    output logic       ov7670_vsync,
    output logic       ov7670_href,
    output logic [7:0] ov7670_data,
    output logic       frame_done,
    output logic [7:0] frame_count
);

    localparam int LINE_CLKS = 2 * H_PIXELS + H_BLANK_CLKS;
    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(LINE_CLKS - 1);
    localparam logic [CNT_W-1:0] HREF_END = CNT_W'(2 * H_PIXELS);

    state_t           state;
    state_t           nxt_state;
    logic [CNT_W-1:0] col;
    logic [CNT_W-1:0] line;
    logic [CNT_W-1:0] nxt_col;
    logic [CNT_W-1:0] nxt_line;
    logic             pending;
    logic             restart;
    logic             nxt_href;
    logic             nxt_done;
    logic [1:0]       pat_r;
    logic [7:0]       gen_byte;

    function automatic logic [CNT_W-1:0] last_line(input state_t s);
        case (s)
            ST_VSYNC:  return CNT_W'(VSYNC_LINES - 1);
            ST_VBP:    return CNT_W'(VBP_LINES - 1);
            ST_ACTIVE: return CNT_W'(V_LINES - 1);
            default:   return CNT_W'(VFP_LINES - 1);
        endcase
    endfunction

    // Next position in the frame; outputs are registered from this so they
    // line up with the state they describe.
    always_comb begin
        nxt_state = state;
        nxt_col   = col;
        nxt_line  = line;
        restart   = continuous || pending || start;
        if (state == ST_IDLE) begin
            if (restart) begin
                nxt_state = ST_VSYNC;
                nxt_col   = '0;
                nxt_line  = '0;
            end
        end else if (col != COL_LAST) begin
            nxt_col = col + 1'b1;
        end else begin
            nxt_col = '0;
            if (line != last_line(state)) begin
                nxt_line = line + 1'b1;
            end else begin
                nxt_line = '0;
                case (state)
                    ST_VSYNC:  nxt_state = ST_VBP;
                    ST_VBP:    nxt_state = ST_ACTIVE;
                    ST_ACTIVE: nxt_state = ST_VFP;
                    default:   nxt_state = restart ? ST_VSYNC : ST_IDLE;
                endcase
            end
        end
        nxt_href = (nxt_state == ST_ACTIVE) && (nxt_col < HREF_END);
        nxt_done = (nxt_state == ST_VFP) && (nxt_col == COL_LAST)
                   && (nxt_line == last_line(ST_VFP));
    end

    ov7670_pattern_gen u_pattern_gen (
        .pattern     (pat_r),
        .x           ({1'b0, nxt_col[CNT_W-1:1]}),
        .y           (nxt_line),
        .phase       (nxt_col[0]),
        .frame_count (frame_count),
        .data        (gen_byte)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            col          <= '0;
            line         <= '0;
            pending      <= 1'b0;
            pat_r        <= PAT_GRAY;
            ov7670_vsync <= 1'b0;
            ov7670_href  <= 1'b0;
            ov7670_data  <= 8'h00;
            frame_done   <= 1'b0;
            frame_count  <= 8'h00;
        end else if (en) begin
            state <= nxt_state;
            col   <= nxt_col;
            line  <= nxt_line;
            // Entering a frame consumes any queued request; extra pulses collapse.
            if (nxt_state == ST_VSYNC && state != ST_VSYNC) begin
                pat_r   <= pattern_sel;
                pending <= 1'b0;
            end else if (start && state != ST_IDLE) begin
                pending <= 1'b1;
            end
            ov7670_vsync <= (nxt_state == ST_VSYNC);
            ov7670_href  <= nxt_href;
            ov7670_data  <= nxt_href ? gen_byte : 8'h00;
            frame_done   <= nxt_done;
            if (nxt_done) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Bench for ov7670_stream_gen: frame-position reference model checked every
// cycle, plus directed scenarios with hand-computed timing and byte values.
module tb_ov7670_stream_gen;

    localparam int HP = 4;
    localparam int VL = 3;
    localparam int HB = 4;
    localparam int VS = 1;
    localparam int VB = 1;
    localparam int VF = 1;
    localparam int LC = 2 * HP + HB;
    localparam int FRAME = LC * (VS + VB + VL + VF);

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       start;
    logic       continuous;
    logic [1:0] pattern_sel;
    logic       vsync;
    logic       href;
    logic [7:0] data;
    logic       done;
    logic [7:0] fc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ov7670_stream_gen #(
        .H_PIXELS(HP), .V_LINES(VL), .H_BLANK_CLKS(HB),
        .VSYNC_LINES(VS), .VBP_LINES(VB), .VFP_LINES(VF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .start        (start),
        .continuous   (continuous),
        .pattern_sel  (pattern_sel),
        .ov7670_vsync (vsync),
        .ov7670_href  (href),
        .ov7670_data  (data),
        .frame_done   (done),
        .frame_count  (fc)
    );

    // Reference model: a frame is just a position 0..FRAME-1 in enabled clocks.
    bit         m_valid = 0;
    bit         m_act = 0;
    int         m_t = 0;
    logic [7:0] m_fc = 8'h00;
    logic [1:0] m_pat = 2'd0;
    bit         m_pend = 0;

    function automatic logic [7:0] exp_y(logic [1:0] p, int x, int y, logic [7:0] f);
        case (p)
            2'd0:    return 8'h80;
            2'd1:    return 8'(x);
            2'd2:    return (((x / 8) + (y / 8)) % 2 == 1) ? 8'hFF : 8'h00;
            default: return 8'(x + int'(f));
        endcase
    endfunction

    function automatic logic [10:0] model_out();
        int         ln;
        int         cl;
        logic       v;
        logic       h;
        logic [7:0] d;
        logic       dn;
        v = 0; h = 0; d = 8'h00; dn = 0;
        if (m_act) begin
            ln = m_t / LC;
            cl = m_t % LC;
            v  = (ln < VS);
            h  = (ln >= VS + VB) && (ln < VS + VB + VL) && (cl < 2 * HP);
            if (h) d = (cl % 2 == 1) ? 8'h80 : exp_y(m_pat, cl / 2, ln - VS - VB, m_fc);
            dn = (m_t == FRAME - 1);
        end
        return {v, h, d, dn};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1;
            m_act   = 0;
            m_t     = 0;
            m_fc    = 8'h00;
            m_pend  = 0;
        end else if (en) begin
            if (!m_act) begin
                if (start || continuous) begin
                    m_act = 1; m_t = 0; m_pat = pattern_sel;
                end
            end else if (m_t == FRAME - 1) begin
                if (continuous || m_pend || start) begin
                    m_t = 0; m_pat = pattern_sel; m_pend = 0;
                end else begin
                    m_act = 0;
                end
            end else begin
                if (start) m_pend = 1;
                m_t++;
                if (m_t == FRAME - 1) m_fc++;
            end
        end
        #1;
        if (m_valid) begin
            checks++;
            if ({vsync, href, data, done, fc} !== {model_out(), m_fc}) begin
                errors++;
                $display("FAIL model @%0t: got vs=%b href=%b data=%h done=%b fc=%0d, expected %b fc=%0d",
                         $time, vsync, href, data, done, fc, model_out(), m_fc);
            end
        end
    end

    // Per-clock record of outputs: [10]=vsync [9]=href [8:1]=data [0]=done
    logic [10:0] rec [0:511];
    int          t;

    task automatic begin_rec();
        for (int i = 0; i < 512; i++) rec[i] = '0;
        t = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
        t++;
        rec[t] = {vsync, href, data, done};
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int cnt_bit(int b, int lo, int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) if (rec[i][b]) n++;
        return n;
    endfunction

    function automatic int first_bit(int b, int lo, int hi);
        for (int i = lo; i <= hi; i++) if (rec[i][b]) return i;
        return -1;
    endfunction

    function automatic int href_rises(int lo, int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) if (rec[i][9] && !rec[i-1][9]) n++;
        return n;
    endfunction

    task automatic do_reset();
        rst = 1;
        steps(2);
        rst = 0;
        step();
    endtask

    logic [7:0] line0 [0:11];

    initial begin
        rst = 1; en = 1; start = 0; continuous = 0; pattern_sel = 2'd0;
        line0 = '{8'h00, 8'h80, 8'h01, 8'h80, 8'h02, 8'h80, 8'h03, 8'h80,
                  8'h00, 8'h00, 8'h00, 8'h00};
        begin_rec();
        do_reset();
        chk("reset_outputs", int'({vsync, href, data, done, fc}), 0);

        // Single frame, ramp pattern; pattern_sel change mid-frame is ignored.
        pattern_sel = 2'd1; start = 1;
        begin_rec();
        step();
        start = 0; pattern_sel = 2'd0;
        steps(89);
        chk("vsync_first", first_bit(10, 1, 90), 1);
        chk("vsync_count", cnt_bit(10, 1, 90), 12);
        chk("vsync_low_13", int'(rec[13][10]), 0);
        chk("href_first", first_bit(9, 1, 90), 25);
        chk("done_first", first_bit(0, 1, 90), 72);
        chk("done_count", cnt_bit(0, 1, 90), 1);
        chk("href_pulses", href_rises(1, 90), 3);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("ramp_byte_%0d", i), int'(rec[25 + i][8:1]), int'(line0[i]));
            chk($sformatf("ramp_href_%0d", i), int'(rec[25 + i][9]), (i < 8) ? 1 : 0);
        end
        chk("fc_after_one", int'(fc), 1);

        // Continuous moving ramp for three frames, dropped during the third.
        do_reset();
        pattern_sel = 2'd3; continuous = 1;
        begin_rec();
        steps(150);
        continuous = 0;
        steps(80);
        chk("cont_done_count", cnt_bit(0, 1, 230), 3);
        chk("cont_done_72", int'(rec[72][0]), 1);
        chk("cont_done_144", int'(rec[144][0]), 1);
        chk("cont_done_216", int'(rec[216][0]), 1);
        chk("cont_vs_73", int'(rec[73][10]), 1);
        chk("cont_vs_145", int'(rec[145][10]), 1);
        chk("cont_y_f0", int'(rec[25][8:1]), 8'h00);
        chk("cont_y_f1", int'(rec[97][8:1]), 8'h01);
        chk("cont_y_f2", int'(rec[169][8:1]), 8'h02);
        chk("cont_idle_vs", cnt_bit(10, 217, 230), 0);
        chk("cont_fc", int'(fc), 3);

        // Clock enable alternating 1,0 starting with the start clock.
        do_reset();
        pattern_sel = 2'd1; start = 1; en = 1;
        begin_rec();
        step();
        start = 0;
        for (int i = 0; i < 159; i++) begin
            en = (t % 2 == 0);
            step();
        end
        en = 1;
        chk("en_done_143", int'(rec[143][0]), 1);
        chk("en_done_144", int'(rec[144][0]), 1);
        chk("en_done_count", cnt_bit(0, 1, 160), 2);
        for (int i = 0; i < 16; i++)
            chk($sformatf("en_byte_%0d", i), int'(rec[49 + i][8:1]), int'(line0[i / 2]));

        // Reset mid-frame aborts; a later start gives a full frame.
        do_reset();
        pattern_sel = 2'd2; start = 1;
        begin_rec();
        step();
        start = 0;
        steps(39);
        rst = 1;
        step();
        rst = 0;
        chk("rst_outputs", int'(rec[41]), 0);
        chk("rst_fc", int'(fc), 0);
        steps(100);
        chk("rst_no_done", cnt_bit(0, 41, 141), 0);
        chk("rst_no_vsync", cnt_bit(10, 41, 141), 0);
        chk("rst_fc_hold", int'(fc), 0);
        start = 1;
        begin_rec();
        step();
        start = 0;
        steps(79);
        chk("rst_refr_done", first_bit(0, 1, 80), 72);
        chk("rst_refr_fc", int'(fc), 1);

        // Two start pulses mid-frame queue exactly one extra frame.
        do_reset();
        pattern_sel = 2'd0; start = 1;
        begin_rec();
        step();
        start = 0;
        steps(9);
        start = 1; step(); start = 0;
        steps(19);
        start = 1; step(); start = 0;
        steps(170);
        chk("pend_done_count", cnt_bit(0, 1, t), 2);
        chk("pend_done_144", int'(rec[144][0]), 1);
        chk("pend_vs_73", int'(rec[73][10]), 1);
        chk("pend_idle", cnt_bit(10, 145, t), 0);
        chk("pend_gray_y", int'(rec[25][8:1]), 8'h80);
        chk("pend_fc", int'(fc), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ov7670_stream_gen.md
OV7670_STREAM_GEN -- requirements
Module: ov7670_stream_gen

Interface
REQ-001 SHALL have parameter H_PIXELS, default 640, active pixels per line.
REQ-002 SHALL have parameter V_LINES, default 480, active lines per frame.
REQ-003 SHALL have parameter H_BLANK_CLKS, default 288, href-low clocks per line.
REQ-004 SHALL have parameters VSYNC_LINES, VBP_LINES and VFP_LINES, defaults 3 / 17 / 10, measured in lines.
REQ-005 SHALL have port clk, input, 1 bit: the single clock of the block.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port en, input, 1 bit: byte-rate clock enable; when 0 all state and outputs hold.
REQ-008 SHALL have port start, input, 1 bit: a one-clock pulse requesting one frame.
REQ-009 SHALL have port continuous, input, 1 bit: level; frames repeat back-to-back while high.
REQ-010 SHALL have port pattern_sel, input, 2 bits: 0 gray, 1 ramp, 2 checkerboard, 3 moving ramp.
REQ-011 SHALL have port ov7670_vsync, output, 1 bit: frame sync, active high.
REQ-012 SHALL have port ov7670_href, output, 1 bit: line valid.
REQ-013 SHALL have port ov7670_data, output, 8 bits: pixel byte.
REQ-014 SHALL have port frame_done, output, 1 bit: one-enabled-clock pulse at end of frame.
REQ-015 SHALL have port frame_count, output, 8 bits: completed frames, wraps 255->0.

Function
REQ-016 SHALL define LINE_CLKS = 2*H_PIXELS + H_BLANK_CLKS; each line spans LINE_CLKS enabled clocks.
REQ-017 SHALL implement the states IDLE, VSYNC, VBP, ACTIVE and VFP, holding VSYNC_LINES, VBP_LINES, V_LINES and VFP_LINES lines respectively.
REQ-018 SHALL, in IDLE with en=1, leave IDLE when start=1 or continuous=1, entering VSYNC on the next clock with ov7670_vsync=1 from that clock.
REQ-019 SHALL keep ov7670_vsync high only in VSYNC, and ov7670_href=0 outside ACTIVE.
REQ-020 SHALL, in ACTIVE, drive ov7670_href=1 for the first 2*H_PIXELS clocks of each line and 0 for the remaining H_BLANK_CLKS.
REQ-021 SHALL send pixel x as 2 bytes, Y first and chroma 0x80 second; ov7670_data=0x00 whenever href=0.
REQ-022 SHALL set Y by pattern: gray=0x80; ramp=x[7:0]; checkerboard=0xFF if x[3]^y[3], else 0x00; moving ramp=(x+frame_count)[7:0]; y is the active line index.
REQ-023 SHALL sample pattern_sel only at VSYNC entry; changes mid-frame take effect on the next frame.
REQ-024 SHALL, at the last clock of VFP, pulse frame_done, increment frame_count, then enter VSYNC if continuous=1 or a start is pending, otherwise IDLE.
REQ-025 SHALL latch a start pulse arriving outside IDLE as one pending request; further pulses are not counted.
REQ-026 SHALL, when continuous falls mid-frame, complete the current frame before returning to IDLE.
REQ-027 SHALL register all outputs and keep them glitch-free; the outputs change only on enabled clocks.

Reset
REQ-028 SHALL, on rst=1 at a clk edge (regardless of en), force IDLE, outputs 0, frame_count=0, pending start cleared, and counters cleared.
REQ-029 SHALL treat rst mid-frame as frame abort: there is no frame_done and no frame_count increment.

Structure
REQ-030 SHALL place the state encoding, pattern codes, chroma constant 0x80 and default timing constants in the shared package ov7670_stream_pkg.
REQ-031 SHALL implement the byte-value generation (pattern, x, y, byte phase -> data) as the sub-module ov7670_pattern_gen; counters and the FSM stay in the top.

Verification
Bench parameters are H_PIXELS=4, V_LINES=3, H_BLANK_CLKS=4 and VSYNC/VBP/VFP=1/1/1, giving LINE_CLKS=12 and a 72-clock frame; en=1 unless stated.
REQ-032 SHALL check: start pulse at clock 0 -> vsync high for clocks 1-12, first href rise at clock 25, frame_done at clock 72, then IDLE.
REQ-033 SHALL check: pattern 1 -> line 0 bytes 00,80,01,80,02,80,03,80, then 4 clocks of href=0 and data=00; exactly 3 href pulses per frame.
REQ-034 SHALL check: continuous=1 for 3 frames -> frame_done every 72 clocks and vsync re-asserts on the clock after each frame_done; pattern 3 line-0 first Y is 00, 01, 02 across the frames.
REQ-035 SHALL check: en toggling 1,0 alternately -> identical byte sequence, each value held 2 clocks; frame_done at clock 144.
REQ-036 SHALL check: rst asserted at clock 40 -> all outputs 0 at clock 41, frame_count stays 0; a new start yields a full frame.
REQ-037 SHALL check: two start pulses during a frame -> exactly one additional frame, then IDLE.
